// File: rtl/piso_pkg.sv
// Shared types and defaults for the PISO transmit scheduler.
package piso_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned GAP_CYCLES_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/piso_tx_scheduler_if.sv
// Two-requester word handshake bundle between producers and the scheduler.
interface piso_tx_scheduler_if
  import piso_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  Req0_Valid_In;
  logic [DATA_WIDTH-1:0] Req0_Data_In;
  logic                  Req0_Ready_Out;
  logic                  Req1_Valid_In;
  logic [DATA_WIDTH-1:0] Req1_Data_In;
  logic                  Req1_Ready_Out;

  modport master (
    output Req0_Valid_In, Req0_Data_In, Req1_Valid_In, Req1_Data_In,
    input  Req0_Ready_Out, Req1_Ready_Out
  );

  modport slave (
    input  Req0_Valid_In, Req0_Data_In, Req1_Valid_In, Req1_Data_In,
    output Req0_Ready_Out, Req1_Ready_Out
  );

endinterface

// File: rtl/piso_shift_reg.sv
// Falling-edge load/shift register; load wins over shift, zero fill, LSB out.
module piso_shift_reg
  import piso_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  serial_out
);

  logic [DATA_WIDTH-1:0] sreg_q;

  // Load a new word or shift right by one with zero fill.
  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      sreg_q <= '0;
    end else if (load) begin
      sreg_q <= load_data;
    end else if (shift) begin
      sreg_q <= {1'b0, sreg_q[DATA_WIDTH-1:1]};
    end
  end

  assign serial_out = sreg_q[0];

endmodule

// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler sharing one PISO register between two word requesters.
module piso_tx_scheduler
  import piso_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic               Clk_In,
  input  logic               Reset_In,
  piso_tx_scheduler_if.slave req_if,
  output logic               Serial_Data_Out,
  output logic               Serial_Valid_Out,
  output logic               Frame_Start_Out,
  output logic               Frame_End_Out,
  output logic               Grant_Id_Out,
  output logic               Busy_Out
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
  localparam int unsigned GAP_W = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

  state_e                state_q;
  state_e                state_d;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [GAP_W-1:0]      gap_cnt_q;
  req_id_t               last_served_q;
  req_id_t               grant_q;
  logic                  win_valid_c;
  req_id_t               win_id_c;
  logic [DATA_WIDTH-1:0] win_data_c;
  logic                  accept_c;

  // Arbiter: single requester wins outright, a tie goes to the one not served last.
  always_comb begin
    win_valid_c = 1'b0;
    win_id_c    = 1'b0;
    if (req_if.Req0_Valid_In && req_if.Req1_Valid_In) begin
      win_valid_c = 1'b1;
      win_id_c    = ~last_served_q;
    end else if (req_if.Req0_Valid_In) begin
      win_valid_c = 1'b1;
      win_id_c    = 1'b0;
    end else if (req_if.Req1_Valid_In) begin
      win_valid_c = 1'b1;
      win_id_c    = 1'b1;
    end
    win_data_c = win_id_c ? req_if.Req1_Data_In : req_if.Req0_Data_In;
  end

  // State register.
  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, handshake and frame-marker decode.
  always_comb begin
    state_d               = state_q;
    accept_c              = 1'b0;
    req_if.Req0_Ready_Out = 1'b0;
    req_if.Req1_Ready_Out = 1'b0;
    Serial_Valid_Out      = 1'b0;
    Frame_Start_Out       = 1'b0;
    Frame_End_Out         = 1'b0;
    Busy_Out              = 1'b1;
    unique case (state_q)
      IDLE: begin
        Busy_Out = 1'b0;
        // Reset gating keeps Ready low while reset is held.
        if (win_valid_c && !Reset_In) begin
          accept_c              = 1'b1;
          req_if.Req0_Ready_Out = ~win_id_c;
          req_if.Req1_Ready_Out = win_id_c;
          state_d               = SHIFT;
        end
      end
      SHIFT: begin
        Serial_Valid_Out = 1'b1;
        Frame_Start_Out  = (bit_cnt_q == '0);
        Frame_End_Out    = (bit_cnt_q == BIT_LAST);
        if (bit_cnt_q == BIT_LAST) begin
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bit/gap counters saturate at their terminal counts; grant bookkeeping on accept.
  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      last_served_q <= 1'b1;
      grant_q       <= 1'b0;
    end else begin
      if (accept_c) begin
        bit_cnt_q     <= '0;
        last_served_q <= win_id_c;
        grant_q       <= win_id_c;
      end else if (state_q == SHIFT && bit_cnt_q != BIT_LAST) begin
        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
      end
      if (state_q != GAP) begin
        gap_cnt_q <= '0;
      end else if (gap_cnt_q != GAP_LAST) begin
        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
      end
    end
  end

  assign Grant_Id_Out = grant_q;

  // Shared shift register: loads on accept, shifts every SHIFT cycle.
  piso_shift_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shift_reg (
    .Clk_In    (Clk_In),
    .Reset_In  (Reset_In),
    .load      (accept_c),
    .shift     (state_q == SHIFT),
    .load_data (win_data_c),
    .serial_out(Serial_Data_Out)
  );

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Scoreboard bench for piso_tx_scheduler (GAP_CYCLES=1 main instance, GAP_CYCLES=0 side instance).
module tb_piso_tx_scheduler;
  import piso_pkg::*;

  localparam int unsigned DW = 16;

  typedef struct packed {
    logic d;
    logic st;
    logic en;
    logic gid;
  } exp_bit_t;

  logic clk;
  logic rst;

  piso_tx_scheduler_if #(.DATA_WIDTH(DW)) bus ();
  piso_tx_scheduler_if #(.DATA_WIDTH(DW)) bus_g0 ();

  logic sd, sv, fs, fe, gid, busy;
  logic sd_g0, sv_g0, fs_g0, fe_g0, gid_g0, busy_g0;

  piso_tx_scheduler #(.DATA_WIDTH(DW), .GAP_CYCLES(1)) dut (
    .Clk_In          (clk),
    .Reset_In        (rst),
    .req_if          (bus.slave),
    .Serial_Data_Out (sd),
    .Serial_Valid_Out(sv),
    .Frame_Start_Out (fs),
    .Frame_End_Out   (fe),
    .Grant_Id_Out    (gid),
    .Busy_Out        (busy)
  );

  piso_tx_scheduler #(.DATA_WIDTH(DW), .GAP_CYCLES(0)) dut_g0 (
    .Clk_In          (clk),
    .Reset_In        (rst),
    .req_if          (bus_g0.slave),
    .Serial_Data_Out (sd_g0),
    .Serial_Valid_Out(sv_g0),
    .Frame_Start_Out (fs_g0),
    .Frame_End_Out   (fe_g0),
    .Grant_Id_Out    (gid_g0),
    .Busy_Out        (busy_g0)
  );

  // Falling edges at 5,15,25...; outputs sampled on rising edges.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  exp_bit_t    sb_q[$];
  logic        grant_log[$];
  int unsigned start_times[$];
  int unsigned cyc      = 0;
  int unsigned acc_cnt  = 0;
  int unsigned end_cnt  = 0;
  int unsigned rdy0_cnt = 0;
  int unsigned rdy1_cnt = 0;

  task automatic push_word(input logic [DW-1:0] w, input logic g);
    for (int k = 0; k < DW; k++) begin
      sb_q.push_back('{d: w[k], st: (k == 0), en: (k == DW - 1), gid: g});
    end
    acc_cnt++;
    grant_log.push_back(g);
  endtask

  // Monitor: pops expected bits on rising edges, records handshakes just before each falling edge.
  initial begin : monitor
    exp_bit_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        if (fs) start_times.push_back(cyc);
        if (fe) end_cnt++;
        if (sv) begin
          chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("ser_data", 32'(sd), 32'(e.d));
            chk("ser_start", 32'(fs), 32'(e.st));
            chk("ser_end", 32'(fe), 32'(e.en));
            chk("ser_gid", 32'(gid), 32'(e.gid));
          end
        end else begin
          chk("quiet_data", 32'(sd), 32'd0);
          chk("quiet_marks", 32'({fs, fe}), 32'd0);
        end
      end
      #3;
      if (rst) begin
        sb_q.delete();
      end else begin
        chk("rdy_excl", 32'(bus.Req0_Ready_Out && bus.Req1_Ready_Out), 32'd0);
        chk("rdy_idle", 32'((bus.Req0_Ready_Out || bus.Req1_Ready_Out) && busy), 32'd0);
        if (bus.Req0_Ready_Out) rdy0_cnt++;
        if (bus.Req1_Ready_Out) rdy1_cnt++;
        if (bus.Req0_Valid_In && bus.Req0_Ready_Out) push_word(bus.Req0_Data_In, 1'b0);
        else if (bus.Req1_Valid_In && bus.Req1_Ready_Out) push_word(bus.Req1_Data_In, 1'b1);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    drive_step();
    rst = 1'b1;
    drive_step();
    rst = 1'b0;
  endtask

  // Wait up to n cycles for acc_cnt to move past base; returns at +2 after the bit-0 edge.
  task automatic wait_accept(input int unsigned base, input string tag);
    logic ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (acc_cnt != base) begin
        ok = 1'b1;
        break;
      end
    end
    #2;
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    #2;
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic send0(input logic [DW-1:0] w, input string tag);
    int unsigned base;
    drive_step();
    base = acc_cnt;
    bus.Req0_Valid_In = 1'b1;
    bus.Req0_Data_In  = w;
    wait_accept(base, tag);
    bus.Req0_Valid_In = 1'b0;
  endtask

  initial begin : stim
    int unsigned base_acc, base_r0, base_r1, base_gl, base_st, base_end;
    int unsigned g0_starts[$];
    int unsigned g0_idle;
    logic ok;

    rst = 1'b1;
    bus.Req0_Valid_In = 1'b0; bus.Req0_Data_In = '0;
    bus.Req1_Valid_In = 1'b0; bus.Req1_Data_In = '0;
    bus_g0.Req0_Valid_In = 1'b0; bus_g0.Req0_Data_In = '0;
    bus_g0.Req1_Valid_In = 1'b0; bus_g0.Req1_Data_In = '0;

    // Reset state, with a request pending that must not be acknowledged.
    repeat (3) @(posedge clk);
    #2;
    bus.Req0_Valid_In = 1'b1;
    bus.Req0_Data_In  = 16'hA5C3;
    #1;
    chk("rst_ready0", 32'(bus.Req0_Ready_Out), 32'd0);
    chk("rst_outputs", 32'({sd, sv, fs, fe, gid, busy}), 32'd0);
    bus.Req0_Valid_In = 1'b0;
    drive_step();
    rst = 1'b0;

    // Single word from Req0, then one gap cycle.
    base_r0  = rdy0_cnt;
    base_acc = acc_cnt;
    send0(16'hA5C3, "t1_accept");
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (fe) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t1_end_seen", 32'(ok), 32'd1);
    @(posedge clk);
    chk("t1_gap_busy", 32'(busy), 32'd1);
    chk("t1_gap_valid", 32'(sv), 32'd0);
    @(posedge clk);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_ready_cycles", rdy0_cnt - base_r0, 32'd1);
    chk("t1_accepts", acc_cnt - base_acc, 32'd1);

    // Continuous tie: alternating grants, 18-cycle frame period.
    do_reset();
    base_acc = acc_cnt;
    base_gl  = grant_log.size();
    base_st  = start_times.size();
    bus.Req0_Valid_In = 1'b1; bus.Req0_Data_In = 16'h0001;
    bus.Req1_Valid_In = 1'b1; bus.Req1_Data_In = 16'h8000;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (acc_cnt - base_acc >= 4) break;
    end
    #2;
    bus.Req0_Valid_In = 1'b0;
    bus.Req1_Valid_In = 1'b0;
    chk("t2_accepts", acc_cnt - base_acc, 32'd4);
    wait_idle("t2_drain");
    for (int i = 0; i < 4; i++) begin
      if (grant_log.size() > base_gl + i) chk($sformatf("t2_grant%0d", i), 32'(grant_log[base_gl + i]), 32'(i % 2));
      else chk($sformatf("t2_grant%0d_present", i), 32'(grant_log.size()), 32'(base_gl + i + 1));
    end
    chk("t2_starts", 32'(start_times.size() - base_st), 32'd4);
    for (int i = 1; i < 4; i++) begin
      if (start_times.size() > base_st + i)
        chk($sformatf("t2_period%0d", i), start_times[base_st + i] - start_times[base_st + i - 1], 32'd18);
    end

    // Reset at bit 7 of 16'hFFFF from Req0; next tie goes to Req0.
    base_end = end_cnt;
    send0(16'hFFFF, "t3_accept");
    repeat (7) @(posedge clk);
    chk("t3_bit7_before", 32'(sd), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t3_async_data", 32'(sd), 32'd0);
    chk("t3_async_flags", 32'({sv, fe, busy}), 32'd0);
    drive_step();
    drive_step();
    rst = 1'b0;
    chk("t3_no_frame_end", end_cnt - base_end, 32'd0);
    base_acc = acc_cnt;
    base_gl  = grant_log.size();
    bus.Req0_Valid_In = 1'b1; bus.Req0_Data_In = 16'h1357;
    bus.Req1_Valid_In = 1'b1; bus.Req1_Data_In = 16'h2468;
    wait_accept(base_acc, "t3_tie_accept");
    if (grant_log.size() > base_gl) chk("t3_tie_winner", 32'(grant_log[base_gl]), 32'd0);
    bus.Req0_Valid_In = 1'b0;
    wait_accept(base_acc + 1, "t3_second_accept");
    bus.Req1_Valid_In = 1'b0;
    if (grant_log.size() > base_gl + 1) chk("t3_second_winner", 32'(grant_log[base_gl + 1]), 32'd1);
    wait_idle("t3_drain");

    // Req1 requests only while a Req0 frame is shifting.
    base_r1 = rdy1_cnt;
    send0(16'h3C5A, "t4_accept");
    base_acc = acc_cnt;
    bus.Req1_Valid_In = 1'b1;
    bus.Req1_Data_In  = 16'hBEEF;
    repeat (5) drive_step();
    bus.Req1_Valid_In = 1'b0;
    wait_idle("t4_drain");
    repeat (3) @(posedge clk);
    chk("t4_no_accept", acc_cnt - base_acc, 32'd0);
    chk("t4_no_ready1", rdy1_cnt - base_r1, 32'd0);
    chk("t4_grant_kept", 32'(gid), 32'd0);

    // GAP_CYCLES=0: back-to-back Req1 frames, 17-cycle period, one idle cycle between.
    drive_step();
    bus_g0.Req1_Valid_In = 1'b1;
    bus_g0.Req1_Data_In  = 16'hC001;
    g0_idle = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      chk("g0_ready0_low", 32'(bus_g0.Req0_Ready_Out), 32'd0);
      if (fs_g0) begin
        g0_starts.push_back(cyc);
        chk("g0_bit0", 32'(sd_g0), 32'd1);
        chk("g0_gid", 32'(gid_g0), 32'd1);
        if (g0_starts.size() == 3) break;
      end else if (g0_starts.size() != 0 && !busy_g0) begin
        g0_idle++;
      end
    end
    #2;
    bus_g0.Req1_Valid_In = 1'b0;
    chk("g0_starts", 32'(g0_starts.size()), 32'd3);
    if (g0_starts.size() == 3) begin
      chk("g0_period1", g0_starts[1] - g0_starts[0], 32'd17);
      chk("g0_period2", g0_starts[2] - g0_starts[1], 32'd17);
    end
    chk("g0_idle_cycles", g0_idle, 32'd2);
    repeat (20) @(posedge clk);
    chk("g0_drained", 32'(busy_g0), 32'd0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
